// File: rtl/shift_seq_pkg.sv
// Shared state encoding and count clamp for the shift-register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int unsigned clamp_cnt(int unsigned n, int unsigned lim);
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/shift_register_sequencer_if.sv
// Datapath <-> sequencer handshake bundle; pause exists only when SHIFT_PAUSE_EN is defined.
interface shift_register_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic [CNT_W-1:0] n_shift;
  logic             abort;
`ifdef SHIFT_PAUSE_EN
  logic             pause;
`endif
  logic             Par_load;
  logic             shift_en;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;
  logic             done;

`ifdef SHIFT_PAUSE_EN
  modport master (output start, n_shift, abort, pause,
                  input  Par_load, shift_en, bit_cnt, busy, done);
  modport slave  (input  start, n_shift, abort, pause,
                  output Par_load, shift_en, bit_cnt, busy, done);
`else
  modport master (output start, n_shift, abort,
                  input  Par_load, shift_en, bit_cnt, busy, done);
  modport slave  (input  start, n_shift, abort,
                  output Par_load, shift_en, bit_cnt, busy, done);
`endif
endinterface

// File: rtl/shift_seq_counter.sv
// Shift counter with clear/enable; last flags the edge on which cnt reaches tgt.
module shift_seq_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tgt,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  logic [CNT_W:0] cnt_inc;

  // Compare one bit wider so tgt==0 never matches through wrap-around.
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last    = (cnt_inc == {1'b0, tgt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt_inc[CNT_W-1:0];
  end
endmodule

// File: rtl/shift_register_sequencer.sv
// Load-then-shift sequencer for one external parallel-load shift register.
// Optional SHIFT_PAUSE_EN adds a pause input that stalls the SHIFT phase.
module shift_register_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                       clk,
  input logic                       rst,
  shift_register_sequencer_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             pause_w;
  logic             par_q, sh_q, busy_q, done_q;

`ifdef SHIFT_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  shift_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == ST_IDLE) && bus.start),
    .en   ((state == ST_SHIFT) && !bus.abort && !pause_w),
    .tgt  (tgt),
    .cnt  (cnt),
    .last (last)
  );

  // Outputs are registered together with the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      tgt    <= '0;
      par_q  <= 1'b0;
      sh_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tgt    <= CNT_W'(clamp_cnt(32'(bus.n_shift), WIDTH));
            state  <= ST_LOAD;
            par_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          par_q <= 1'b0;
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (tgt == '0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= ST_SHIFT;
            sh_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            sh_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (!pause_w && last) begin
            state  <= ST_DONE;
            sh_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          par_q  <= 1'b0;
          sh_q   <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Par_load = par_q;
  assign bus.shift_en = sh_q & ~pause_w;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bit_cnt  = cnt;
endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: queue-of-scheduled-cycles reference model plus directed timing checks.
module tb_shift_register_sequencer;
  localparam int W   = 24;
  localparam int CW  = 5;
  localparam int W2  = 80;
  localparam int CW2 = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_register_sequencer_if #(.CNT_W(CW))  b24 ();
  shift_register_sequencer_if #(.CNT_W(CW2)) b80 ();

  shift_register_sequencer #(.WIDTH(W))  dut24 (.clk(clk), .rst(rst), .bus(b24));
  shift_register_sequencer #(.WIDTH(W2)) dut80 (.clk(clk), .rst(rst), .bus(b80));

  int errors = 0;
  int checks = 0;

  // Model: list of scheduled cycle kinds (1=load, 2=shift, 3=done); empty means idle.
  int   q[$];
  int   m_cnt;
  logic cur_start, cur_abort, cur_pause;
  int   cur_n;

  int cyc = 0;
  int s_cyc, done_cyc, sh_cnt, par_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (q.size() == 0) begin
      if (cur_start) begin
        int t;
        t = (cur_n > W) ? W : cur_n;
        m_cnt = 0;
        q.push_back(1);
        repeat (t) q.push_back(2);
        q.push_back(3);
      end
    end else begin
      case (q[0])
        1: if (cur_abort) q.delete(); else void'(q.pop_front());
        2: begin
          if (cur_abort) q.delete();
          else if (!cur_pause) begin
            m_cnt++;
            void'(q.pop_front());
          end
        end
        default: void'(q.pop_front());
      endcase
    end
  endtask

  task automatic drive(input logic s, input int n, input logic a, input logic p);
    cur_start = s; cur_n = n; cur_abort = a; cur_pause = p;
    b24.start   = s;
    b24.n_shift = CW'(n);
    b24.abort   = a;
`ifdef SHIFT_PAUSE_EN
    b24.pause   = p;
`endif
  endtask

  task automatic run_cycle(input logic s, input int n, input logic a, input logic p);
    int       head;
    logic [3:0] e;
    @(posedge clk);
    model_step();
    #1;
    drive(s, n, a, p);
    cyc++;
    @(negedge clk);
    head = (q.size() != 0) ? q[0] : 0;
    e = {head == 1, (head == 2) && !cur_pause, (head == 1) || (head == 2), head == 3};
    chk("ctl{par,sh,busy,done}", 32'({b24.Par_load, b24.shift_en, b24.busy, b24.done}), 32'(e));
    chk("bit_cnt", 32'(b24.bit_cnt), 32'(m_cnt));
    if (b24.done && done_cyc < 0) done_cyc = cyc;
    if (b24.shift_en) sh_cnt++;
    if (b24.Par_load) par_cnt++;
  endtask

  task automatic idle(input int k);
    repeat (k) run_cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic start_job(input int n);
    run_cycle(1'b1, n, 1'b0, 1'b0);
    s_cyc = cyc; done_cyc = -1; sh_cnt = 0; par_cnt = 0;
  endtask

  task automatic run80(input int n);
    int sh = 0;
    int dk = -1;
    @(posedge clk); #1;
    b80.start = 1'b1; b80.n_shift = CW2'(n);
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      b80.start = 1'b0;
      @(negedge clk);
      if (b80.shift_en) sh++;
      if (b80.done && dk < 0) dk = k;
    end
    chk("w80_shift_cycles", 32'(sh), 32'(W2));
    chk("w80_done_latency", 32'(dk), 32'(W2 + 2));
    chk("w80_bit_cnt", 32'(b80.bit_cnt), 32'(W2));
    chk("w80_busy_after", 32'(b80.busy), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    q.delete(); m_cnt = 0;
    drive(1'b0, 0, 1'b0, 1'b0);
    b80.start = 1'b0; b80.n_shift = '0; b80.abort = 1'b0;
`ifdef SHIFT_PAUSE_EN
    b80.pause = 1'b0;
`endif
    done_cyc = -1; sh_cnt = 0; par_cnt = 0; s_cyc = 0;
    #7;
    chk("reset_ctl", 32'({b24.Par_load, b24.shift_en, b24.busy, b24.done}), 32'(0));
    chk("reset_bit_cnt", 32'(b24.bit_cnt), 32'(0));
    #5 rst = 1'b0;

    // Full-width job.
    start_job(24);
    idle(30);
    chk("t1_par_cycles", 32'(par_cnt), 32'(1));
    chk("t1_shift_cycles", 32'(sh_cnt), 32'(24));
    chk("t1_done_latency", 32'(done_cyc - s_cyc), 32'(26));
    chk("t1_bit_cnt_hold", 32'(b24.bit_cnt), 32'(24));
    chk("t1_busy_after", 32'(b24.busy), 32'(0));

    // Zero-length job.
    start_job(0);
    idle(5);
    chk("t2_par_cycles", 32'(par_cnt), 32'(1));
    chk("t2_shift_cycles", 32'(sh_cnt), 32'(0));
    chk("t2_done_latency", 32'(done_cyc - s_cyc), 32'(2));

    // Over-range count is clamped.
    start_job(31);
    idle(30);
    chk("t3_shift_cycles", 32'(sh_cnt), 32'(24));
    chk("t3_done_latency", 32'(done_cyc - s_cyc), 32'(26));

    // Start while busy ignored; start in first idle cycle after done accepted.
    start_job(6);
    idle(2);
    run_cycle(1'b1, 2, 1'b0, 1'b0);
    idle(5);
    chk("t4_first_shift_cycles", 32'(sh_cnt), 32'(6));
    chk("t4_first_done_latency", 32'(done_cyc - s_cyc), 32'(8));
    start_job(3);
    idle(1);
    chk("t4_cnt_cleared", 32'(b24.bit_cnt), 32'(0));
    chk("t4_par_load", 32'(b24.Par_load), 32'(1));
    idle(8);
    chk("t4_second_shift_cycles", 32'(sh_cnt), 32'(3));
    chk("t4_second_done_latency", 32'(done_cyc - s_cyc), 32'(5));

    // Abort after five shifts.
    start_job(10);
    idle(6);
    run_cycle(1'b0, 0, 1'b1, 1'b0);
    idle(1);
    chk("t5_busy_after_abort", 32'(b24.busy), 32'(0));
    chk("t5_bit_cnt_after_abort", 32'(b24.bit_cnt), 32'(5));
    idle(5);
    chk("t5_no_done", 32'(done_cyc), 32'(-1));

    // Async reset in the middle of SHIFT.
    start_job(10);
    idle(4);
    rst = 1'b1;
    #1;
    chk("t5_rst_ctl", 32'({b24.Par_load, b24.shift_en, b24.busy, b24.done}), 32'(0));
    chk("t5_rst_bit_cnt", 32'(b24.bit_cnt), 32'(0));
    q.delete(); m_cnt = 0;
    drive(1'b0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

`ifdef SHIFT_PAUSE_EN
    // Three paused cycles stretch the job by three.
    start_job(8);
    idle(3);
    repeat (3) run_cycle(1'b0, 0, 1'b0, 1'b1);
    idle(10);
    chk("t6_shift_cycles", 32'(sh_cnt), 32'(8));
    chk("t6_done_latency", 32'(done_cyc - s_cyc), 32'(13));
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic rs, ra, rp;
      rs = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 19) == 0);
`ifdef SHIFT_PAUSE_EN
      rp = ($urandom_range(0, 3) == 0);
`else
      rp = 1'b0;
`endif
      run_cycle(rs, int'($urandom_range(0, 31)), ra, rp);
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    idle(30);

    // Wide instance.
    run80(80);
    run80(127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
